// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and IF/ID capture with stall, redirect bubble and halt.
// Define FETCH_ALIGN_CHECK_EN to add the sticky fetch_misaligned flag that halts fetch on a misaligned PC.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] instruction_address,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        ifid_valid,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_misaligned,
`endif
  output logic [1:0]  fetch_state
);
  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, HALTED = 2'b10} state_e;
  state_e      state_q;
  logic [31:0] pc_q, pc_step_d, ifid_ins_q, ifid_pc_q, ifid_pc4_q;
  logic        ifid_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misaligned_q;
  assign fetch_misaligned = misaligned_q;
`endif
  assign pc_step_d           = pc_q + PC_STEP;
  assign instruction_address = pc_q;
  assign ifid_valid          = ifid_valid_q;
  assign ifid_instruction    = ifid_ins_q;
  assign ifid_pc             = ifid_pc_q;
  assign ifid_pc_plus4       = ifid_pc4_q;
  assign fetch_state         = state_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_ins_q   <= '0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (redirect_valid) begin
            pc_q         <= redirect_target;
            ifid_valid_q <= 1'b0;
          end else if (!stall) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned_q || pc_q[1:0] != 2'b00) begin
              misaligned_q <= 1'b1;
              ifid_valid_q <= 1'b0;
              state_q      <= HALTED;
            end else
`endif
            begin
              ifid_ins_q   <= instruction;
              ifid_pc_q    <= pc_q;
              ifid_pc4_q   <= pc_step_d;
              ifid_valid_q <= 1'b1;
              if (halt_req) state_q <= HALTED;
              else pc_q <= pc_step_d;
            end
          end
        end
        HALTED: begin
          // a stalled decode keeps the last captured instruction until it drains
          if (redirect_valid) begin
            pc_q         <= redirect_target;
            state_q      <= RUN;
            ifid_valid_q <= 1'b0;
          end else if (!stall) ifid_valid_q <= 1'b0;
        end
        default: state_q <= BOOT;
      endcase
    end
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- PC and fetch stage directly upstream of the instruction memory.
- Holds the program counter and drives the memory's 32-bit instruction address.
- The memory returns the instruction combinationally in the same cycle; this block captures it into an IF/ID pipeline register that feeds decode.
- Supports stall, branch/jump redirect with bubble insertion, and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- instruction_address  output  32  current PC, drives the instruction memory address
- instruction  input  32  instruction word returned by memory for instruction_address, same cycle
- stall  input  1  decode not ready; hold PC and IF/ID contents
- redirect_valid  input  1  branch taken or jump resolved this cycle
- redirect_target  input  32  new PC when redirect_valid=1
- halt_req  input  1  stop fetching after the current cycle
- ifid_valid  output  1  IF/ID register holds a real instruction
- ifid_instruction  output  32  captured instruction
- ifid_pc  output  32  PC of captured instruction
- ifid_pc_plus4  output  32  ifid_pc + PC_STEP, mod 2^32
- fetch_state  output  2  00=BOOT, 01=RUN, 10=HALTED

Behaviour:
- Reset (async, reset_n=0): PC=RESET_PC, state=BOOT, ifid_valid=0, ifid_instruction=0, ifid_pc=0, ifid_pc_plus4=0. Reset mid-operation discards all in-flight state immediately, independent of clk.
- instruction_address = PC at all times, combinational from the PC register.

State machine:
- BOOT: one cycle only; no capture (ifid_valid stays 0); PC holds. Next state is RUN. Masks the first edge after reset release.
- RUN:
  - Priority 1, redirect_valid=1: PC <= redirect_target; ifid_valid <= 0 (flush/bubble). Applies even when stall=1 or halt_req=1. State stays RUN.
  - Priority 2, stall=1: PC, ifid_* and state all hold.
  - Priority 3, halt_req=1: capture the current instruction (ifid_valid <= 1); PC holds; state -> HALTED.
  - Otherwise: ifid_instruction <= instruction, ifid_pc <= PC, ifid_pc_plus4 <= PC+PC_STEP, ifid_valid <= 1, PC <= PC+PC_STEP.
- HALTED:
  - If stall=0, ifid_valid <= 0 on each edge; if stall=1, IF/ID holds so the last instruction drains.
  - PC holds.
  - redirect_valid=1: PC <= redirect_target, state -> RUN, ifid_valid <= 0.
  - halt_req is ignored.

Arithmetic and boundaries:
- PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Latency: an instruction at address A appears on ifid_* one edge after PC==A, provided it is not stalled or flushed.
- Redirect throughput: one bubble per redirect; the target instruction is valid on the 2nd edge after redirect_valid.
- Simultaneous stall and redirect: redirect wins; stall is ignored that cycle.
- redirect_target is used unmodified; alignment is not enforced unless the optional feature is enabled.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Enabled:
  - Adds output port fetch_misaligned (1 bit).
  - Set when PC[1:0]!=0 on a RUN fetch edge; sticky until reset.
  - While set, the block does not capture: ifid_valid <= 0, PC holds, state -> HALTED.
  - A redirect does not clear it.
- Disabled:
  - Port is absent.
  - PC[1:0] is passed to memory unchecked and fetch proceeds normally.

Test Plan:
- Reset with RESET_PC=0, release, 4 free-running edges:
  - Edge 1 (BOOT): ifid_valid=0.
  - Edges 2..4 capture ifid_pc=0,4,8; ifid_pc_plus4=4,8,12.
  - instruction_address=12 afterwards.
- stall=1 for 3 cycles while PC=8: instruction_address stays 8, ifid_* unchanged. After release the next capture has ifid_pc=8.
- redirect_valid=1, redirect_target=32'h40 at PC=16, with stall=1 at the same time:
  - Next edge: PC=0x40, ifid_valid=0.
  - Following edge: ifid_pc=0x40, valid=1.
- halt_req=1 at PC=20:
  - ifid_pc=20 captured; state=HALTED; PC stays 20.
  - Next edge ifid_valid=0.
  - Then redirect to 0 returns to RUN with PC=0.
- PC near wrap: redirect to 32'hFFFF_FFFC, run 2 edges → ifid_pc=FFFF_FFFC, ifid_pc_plus4=0, instruction_address=0.
- With FETCH_ALIGN_CHECK_EN: redirect to 32'h42 → next fetch edge sets fetch_misaligned=1, ifid_valid=0, state=HALTED. Async reset mid-run clears everything.
